// File: rtl/my_processor_keys_in.sv
// Avalon-MM key/switch input port: two-flop synchronizer, per-bit debounce,
// press-edge capture with write-1-to-clear, and a masked level interrupt.
module my_processor_keys_in #(
  parameter int unsigned WIDTH            = 4,
  parameter int unsigned DEBOUNCE_DEFAULT = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_LIMIT = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_CAP   = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [CNT_W-1:0] r_limit;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic             w_wr;
  logic             w_wr_limit;
  logic             w_wr_mask;
  logic             w_wr_cap;
  logic [WIDTH-1:0] w_cap_clr;
  logic [WIDTH-1:0] w_stable_nxt;
  logic [WIDTH-1:0] w_press;
  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic             w_unused;

  // Bus write decode; DATA is read-only so address 0 has no write strobe
  assign w_wr       = chipselect & ~write_n;
  assign w_wr_limit = w_wr & (address == ADDR_LIMIT);
  assign w_wr_mask  = w_wr & (address == ADDR_MASK);
  assign w_wr_cap   = w_wr & (address == ADDR_CAP);
  assign w_cap_clr  = w_wr_cap ? writedata[WIDTH-1:0] : '0;
  assign w_unused   = ^writedata;

  // Raw keys are asynchronous; nothing downstream sees them before two flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Counter only increments while below the limit, so it can never wrap
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] >= r_limit) begin
          w_stable_nxt[i] = r_sync2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Keys are active-low, so a press is a stable 1->0 transition
  assign w_press = r_stable & ~w_stable_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable <= w_stable_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Set is ORed in after the clear so a same-cycle press is never lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_cap_clr) | w_press;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_limit   <= CNT_W'(DEBOUNCE_DEFAULT);
      r_irqmask <= '0;
    end else begin
      if (w_wr_limit) begin
        r_limit <= writedata[CNT_W-1:0];
      end
      if (w_wr_mask) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:  readdata = DATA_W'(r_stable);
      ADDR_LIMIT: readdata = DATA_W'(r_limit);
      ADDR_MASK:  readdata = DATA_W'(r_irqmask);
      ADDR_CAP:   readdata = DATA_W'(r_edgecap);
      default:    readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_my_processor_keys_in.sv
// Bench for my_processor_keys_in: directed and random stimulus, every cycle's
// readdata/irq checked by a monitor against a queued reference expectation.
module tb_my_processor_keys_in;

  localparam int unsigned W        = 4;
  localparam int unsigned LIM_DFLT = 50000;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  my_processor_keys_in #(
    .WIDTH(W),
    .DEBOUNCE_DEFAULT(LIM_DFLT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: each key remembers how many synchronized samples in a
  // row disagreed with its debounced value; the value flips once that run
  // reaches LIMIT+1 samples.
  logic [W-1:0] m_pipe1, m_pipe2, m_stable, m_cap, m_mask;
  logic [W-1:0] m_new, m_press, m_clr;
  int           m_run [W];
  int           m_limit;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pipe1  = '1;
      m_pipe2  = '1;
      m_stable = '1;
      m_cap    = '0;
      m_mask   = '0;
      m_limit  = LIM_DFLT;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_new = m_stable;
      for (int i = 0; i < W; i++) begin
        if (m_pipe2[i] == m_stable[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] > m_limit) begin
            m_new[i] = m_pipe2[i];
            m_run[i] = 0;
          end
        end
      end
      m_press = m_stable & ~m_new;
      m_clr   = '0;
      if (chipselect && !write_n) begin
        case (address)
          2'd1: m_limit = int'(writedata[15:0]);
          2'd2: m_mask  = writedata[W-1:0];
          2'd3: m_clr   = writedata[W-1:0];
          default: ;
        endcase
      end
      m_cap    = (m_cap & ~m_clr) | m_press;
      m_stable = m_new;
      m_pipe2  = m_pipe1;
      m_pipe1  = in_port;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_stable);
      2'd1:    return 32'(m_limit);
      2'd2:    return 32'(m_mask);
      default: return 32'(m_cap);
    endcase
  endfunction

  function automatic logic model_irq();
    return |(m_cap & m_mask);
  endfunction

  // Monitor: readdata is presented every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (readdata !== mon_e.d) begin
        n_errors++;
        $display("FAIL rd_a%0d data: got 0x%08h want 0x%08h at %0t",
                 mon_e.a, readdata, mon_e.d, $time);
      end
      n_checks++;
      if (irq !== mon_e.irq) begin
        n_errors++;
        $display("FAIL irq (addr %0d): got %0b want %0b at %0t",
                 mon_e.a, irq, mon_e.irq, $time);
      end
    end
  end

  // One bus cycle; called just after a rising edge, returns just after the next
  task automatic cyc(input bit wr, input logic [1:0] a, input logic [31:0] d,
                     input bit use_c = 1'b0, input logic [31:0] c = '0,
                     input logic c_irq = 1'b0);
    exp_t e;
    address = a;
    if (wr) begin
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = d;
    end else begin
      chipselect = 1'($urandom_range(0, 1));
      write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
      writedata  = $urandom();
    end
    e.a   = a;
    e.d   = use_c ? c : model_read(a);
    e.irq = use_c ? c_irq : model_irq();
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] d;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '1;
    repeat (2) @(posedge clk);
    #1;

    // During and after reset
    cyc(0, 2'd0, '0, 1, 32'hF, 1'b0);
    cyc(0, 2'd3, '0, 1, 32'h0, 1'b0);
    reset_n = 1'b1;
    cyc(0, 2'd0, '0, 1, 32'hF, 1'b0);
    cyc(0, 2'd1, '0, 1, 32'd50000, 1'b0);
    cyc(0, 2'd2, '0, 1, 32'h0, 1'b0);
    cyc(0, 2'd3, '0, 1, 32'h0, 1'b0);

    // LIMIT=3, hold key 0: DATA bit0 drops after the 6th rising edge
    cyc(1, 2'd1, 32'hABCD_0003);
    in_port = 4'hE;
    for (int k = 0; k <= 7; k++)
      cyc(0, 2'd0, '0, 1, (k >= 6) ? 32'hE : 32'hF, 1'b0);
    cyc(0, 2'd3, '0, 1, 32'h1, 1'b0);

    // Key 1 glitch of three cycles is discarded
    in_port = 4'hC;
    repeat (3) cyc(0, 2'd0, '0, 1, 32'hE, 1'b0);
    in_port = 4'hE;
    repeat (6) cyc(0, 2'd0, '0, 1, 32'hE, 1'b0);
    cyc(0, 2'd3, '0, 1, 32'h1, 1'b0);

    // Masking and write-1-to-clear
    cyc(1, 2'd2, 32'hFFFF_FFF2);
    cyc(0, 2'd3, '0, 1, 32'h1, 1'b0);
    cyc(1, 2'd2, 32'h0000_0003);
    cyc(0, 2'd2, '0, 1, 32'h3, 1'b1);
    cyc(1, 2'd3, 32'h0000_0001);
    cyc(0, 2'd3, '0, 1, 32'h0, 1'b0);
    cyc(1, 2'd0, 32'h0000_0000);
    cyc(0, 2'd0, '0, 1, 32'hE, 1'b0);

    // LIMIT=0; press key 2, release, then press again while clearing it
    cyc(1, 2'd1, 32'h0000_0000);
    in_port = 4'hA;
    repeat (4) cyc(0, 2'd3, '0);
    in_port = 4'hE;
    repeat (4) cyc(0, 2'd0, '0);
    cyc(0, 2'd3, '0, 1, 32'h4, 1'b0);
    in_port = 4'hA;
    cyc(0, 2'd0, '0);
    cyc(0, 2'd0, '0);
    cyc(1, 2'd3, 32'h0000_0004);
    cyc(0, 2'd3, '0, 1, 32'h4, 1'b0);
    cyc(0, 2'd0, '0, 1, 32'hA, 1'b0);

    // LIMIT=1000, ~500 mismatches, then lower LIMIT to 10
    cyc(1, 2'd1, 32'd1000);
    in_port = 4'h2;
    repeat (502) cyc(0, 2'd0, '0, 1, 32'hA, 1'b0);
    cyc(1, 2'd1, 32'd10);
    cyc(0, 2'd0, '0, 1, 32'hA, 1'b0);
    cyc(0, 2'd0, '0, 1, 32'h2, 1'b0);
    cyc(0, 2'd3, '0, 1, 32'hC, 1'b0);

    // Reset pulse mid-count, key still held across release
    cyc(1, 2'd1, 32'd1000);
    in_port = 4'h0;
    repeat (200) cyc(0, 2'd0, '0, 1, 32'h2, 1'b0);
    reset_n = 1'b0;
    cyc(0, 2'd0, '0, 1, 32'hF, 1'b0);
    cyc(0, 2'd3, '0, 1, 32'h0, 1'b0);
    cyc(0, 2'd1, '0, 1, 32'd50000, 1'b0);
    reset_n = 1'b1;
    cyc(1, 2'd1, 32'd5);
    repeat (12) cyc(0, 2'd0, '0);
    cyc(0, 2'd0, '0, 1, 32'h0, 1'b0);
    cyc(0, 2'd3, '0, 1, 32'hF, 1'b0);
    cyc(0, 2'd1, '0, 1, 32'd5, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0)
        in_port = in_port ^ (W'(1) << $urandom_range(0, W - 1));
      r = int'($urandom_range(0, 11));
      case (r)
        0: begin
          d = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
          cyc(1, 2'd1, d);
        end
        1: cyc(1, 2'd2, $urandom());
        2: cyc(1, 2'd3, $urandom() & $urandom());
        3: cyc(1, 2'd0, $urandom());
        default: cyc(0, 2'($urandom_range(0, 3)), '0);
      endcase
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/my_processor_keys_in.md
MY_PROCESSOR_KEYS_IN -- requirements
Module: my_processor_keys_in

Interface
REQ-001 Parameter WIDTH, default 4: number of input bits (keys/switches); range 1..16.
REQ-002 Parameter DEBOUNCE_DEFAULT, default 50000: reset value of the debounce limit register; 16-bit unsigned.
REQ-003 clk  input  1  system clock; all state SHALL be updated on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  2  Avalon-MM register select.
REQ-006 chipselect  input  1  slave select; write takes effect only when high.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  read data; combinational from address, zero wait states, no read strobe.
REQ-010 in_port  input  WIDTH  raw asynchronous key inputs; active-low (pressed = 0).
REQ-011 irq  output  1  level interrupt request to the processor.

Function
REQ-012 Register map SHALL be: 0 DATA (RO), 1 LIMIT (RW, bits 15:0), 2 IRQMASK (RW, bits WIDTH-1:0), 3 EDGECAP (read; write-1-to-clear).
REQ-013 Write condition SHALL be chipselect && !write_n; writes to address 0 SHALL be ignored; unused writedata bits SHALL be ignored.
REQ-014 readdata SHALL return the selected register zero-extended to 32 bits; unimplemented bits read 0.
REQ-015 Each in_port bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-016 Each bit SHALL have an independent 16-bit debounce counter and one stable bit.
REQ-017 Per cycle per bit: if sync == stable, the counter SHALL clear to 0.
REQ-018 If sync != stable and counter >= LIMIT, stable SHALL take sync and the counter SHALL clear; otherwise the counter SHALL increment by 1.
REQ-019 Consequently stable SHALL change only after LIMIT+1 consecutive mismatched cycles; shorter glitches SHALL be discarded.
REQ-020 LIMIT = 0 SHALL make stable follow sync with one cycle of debounce latency.
REQ-021 A LIMIT write SHALL take effect the next cycle; a counter already >= the new LIMIT SHALL resolve on the next mismatched cycle, and the counter SHALL never wrap.
REQ-022 DATA SHALL read the stable vector.
REQ-023 A stable 1->0 transition (press) SHALL set the corresponding EDGECAP bit; 0->1 (release) SHALL NOT set it.
REQ-024 A write to address 3 SHALL clear every EDGECAP bit whose writedata bit is 1; bits written 0 SHALL be unchanged.
REQ-025 If a set and a clear hit the same EDGECAP bit in the same cycle, set SHALL win.
REQ-026 EDGECAP bits SHALL remain set until cleared; further presses on a set bit SHALL have no additional effect.
REQ-027 irq SHALL equal OR-reduce(EDGECAP & IRQMASK), combinational from registers; no latency beyond the register update.
REQ-028 Changing IRQMASK SHALL NOT alter EDGECAP; masked captured edges SHALL assert irq immediately when unmasked.

Reset
REQ-029 On reset_n low, synchronizer flops and stable bits SHALL be all 1 (released), counters 0, EDGECAP 0, IRQMASK 0, LIMIT = DEBOUNCE_DEFAULT.
REQ-030 During reset: irq SHALL be 0 and DATA SHALL read all ones (2^WIDTH-1).
REQ-031 Reset asserted mid-debounce SHALL abandon the count; no edge SHALL be captured from pre-reset activity.
REQ-032 After reset release with in_port held low, the press SHALL be debounced normally and SHALL set EDGECAP.

Verification
REQ-033 Reset, read all addresses -> DATA=0xF, LIMIT=50000, IRQMASK=0, EDGECAP=0, irq=0.
REQ-034 LIMIT=3; in_port[0] 1->0 held -> DATA bit0 reads 0 after 6th rising edge (2 sync + 4 debounce); EDGECAP=0x1.
REQ-035 LIMIT=3; in_port[1] low for 3 cycles then high -> DATA stays 0xF, EDGECAP stays 0.
REQ-036 IRQMASK=0x2, press key 0 -> EDGECAP=0x1, irq=0; write IRQMASK=0x3 -> irq=1; write EDGECAP=0x1 -> EDGECAP=0, irq=0.
REQ-037 EDGECAP clear write in the same cycle as a new key-2 press -> EDGECAP bit2 remains 1.
REQ-038 LIMIT=1000, counter at 500 mismatches, write LIMIT=10 -> stable updates on next mismatched cycle; reset_n pulse mid-count -> DATA=0xF, EDGECAP=0.
